// File: rtl/lcd_backlight_ctrl_if.sv
// ---------------------------------------------------------------------------
// lcd_backlight_ctrl_if
// Register bus between a host and the LCD backlight controller.
//   address    : 2-bit register select (host -> controller)
//   chipselect : slave select (host -> controller)
//   write_n    : active-low write strobe (host -> controller)
//   writedata  : 32-bit write data (host -> controller)
//   readdata   : 32-bit read data, combinational (controller -> host)
// ---------------------------------------------------------------------------
interface lcd_backlight_ctrl_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/lcd_backlight_ctrl.sv
// ---------------------------------------------------------------------------
// lcd_backlight_ctrl
// PWM backlight controller with glitch-free duty updates and an optional
// linear fade (one duty step per PWM period).
//   clk      : single clock
//   reset_n  : synchronous active-low reset
//   bus      : register bus (slave side), registers CTRL/PERIOD/TARGET/STATUS
//   out_port : registered PWM output
//   busy     : high while a fade is in progress
// ---------------------------------------------------------------------------
module lcd_backlight_ctrl #(
    parameter int unsigned CLK_DIV    = 4,
    parameter int unsigned RST_PERIOD = 1000,
    parameter int unsigned RST_DUTY   = 0
) (
    input  logic                clk,
    input  logic                reset_n,
    lcd_backlight_ctrl_if.slave bus,
    output logic                out_port,
    output logic                busy
);
    typedef enum logic [1:0] {S_OFF, S_RUN, S_RAMP} state_t;

    localparam logic [15:0] PRE_LAST   = 16'(CLK_DIV - 1);
    localparam logic [15:0] PERIOD_RST = 16'(RST_PERIOD);
    localparam logic [15:0] DUTY_RST   = 16'(RST_DUTY);

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic        fade_q, fade_d;
    logic [15:0] period_q, period_d;
    logic [15:0] target_q, target_d;
    logic [15:0] duty_q, duty_d;
    logic [15:0] cnt_q, cnt_d;
    logic [15:0] pre_q, pre_d;
    logic        out_q, out_d;

    logic        wr;
    logic        active;
    logic        tick;
    logic        pb;
    logic [15:0] step;
    logic        unused_wd;

    assign unused_wd = ^bus.writedata[31:16];

    // Register writes and combinational read-back.
    always_comb begin
        wr       = bus.chipselect && !bus.write_n;
        en_d     = en_q;
        fade_d   = fade_q;
        period_d = period_q;
        target_d = target_q;
        if (wr) begin
            case (bus.address)
                2'd0: begin
                    en_d   = bus.writedata[0];
                    fade_d = bus.writedata[1];
                end
                2'd1:    period_d = bus.writedata[15:0];
                2'd2:    target_d = bus.writedata[15:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        case (bus.address)
            2'd0:    bus.readdata = {30'd0, fade_q, en_q};
            2'd1:    bus.readdata = {16'd0, period_q};
            2'd2:    bus.readdata = {16'd0, target_q};
            default: bus.readdata = {duty_q, 15'd0, busy};
        endcase
    end

    // Prescaler and PWM counter. The wrap test uses ">=" so a PERIOD
    // written below the running count wraps on the next tick, and
    // PERIOD=0 yields a boundary on every tick with cnt pinned at 0.
    always_comb begin
        active = en_q && (state_q != S_OFF);
        tick   = active && (pre_q == PRE_LAST);
        pb     = tick && (({1'b0, cnt_q} + 17'd1) >= {1'b0, period_q});
        pre_d  = 16'd0;
        cnt_d  = 16'd0;
        if (active) begin
            pre_d = tick ? 16'd0 : pre_q + 16'd1;
            cnt_d = !tick ? cnt_q : (pb ? 16'd0 : cnt_q + 16'd1);
        end
    end

    // Duty FSM. target_d already carries a same-edge TARGET write, so a
    // write coinciding with a period boundary acts on the new value.
    always_comb begin
        state_d = state_q;
        duty_d  = duty_q;
        step    = (duty_q < target_d) ? duty_q + 16'd1 : duty_q - 16'd1;
        if (!en_q) begin
            state_d = S_OFF;
        end else begin
            case (state_q)
                S_OFF: state_d = S_RUN;
                S_RUN: begin
                    if (pb && (duty_q != target_d)) begin
                        if (fade_q) state_d = S_RAMP;
                        else        duty_d  = target_d;
                    end
                end
                S_RAMP: begin
                    if (pb) begin
                        if (!fade_q || (duty_q == target_d)) begin
                            duty_d  = target_d;
                            state_d = S_RUN;
                        end else begin
                            duty_d = step;
                            if (step == target_d) state_d = S_RUN;
                        end
                    end
                end
                default: state_d = S_OFF;
            endcase
        end
        // Output is computed from next-state values so it stays aligned
        // with the registered counter and duty.
        out_d = en_d && (state_d != S_OFF) && (period_d != 16'd0) &&
                (cnt_d < duty_d);
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= S_OFF;
            en_q     <= 1'b0;
            fade_q   <= 1'b0;
            period_q <= PERIOD_RST;
            target_q <= DUTY_RST;
            duty_q   <= DUTY_RST;
            cnt_q    <= 16'd0;
            pre_q    <= 16'd0;
            out_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            en_q     <= en_d;
            fade_q   <= fade_d;
            period_q <= period_d;
            target_q <= target_d;
            duty_q   <= duty_d;
            cnt_q    <= cnt_d;
            pre_q    <= pre_d;
            out_q    <= out_d;
        end
    end

    assign out_port = out_q;
    assign busy     = (state_q == S_RAMP);
endmodule

// File: tb/tb_lcd_backlight_ctrl.sv
// ---------------------------------------------------------------------------
// tb_lcd_backlight_ctrl
// Self-checking bench: directed scenarios plus randomized register traffic,
// compared every clock against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_lcd_backlight_ctrl;
    localparam int CLK_DIV = 4;

    logic clk = 1'b0;
    logic reset_n;
    logic out_port;
    logic busy;

    lcd_backlight_ctrl_if bus_if ();

    lcd_backlight_ctrl #(
        .CLK_DIV   (CLK_DIV),
        .RST_PERIOD(1000),
        .RST_DUTY  (0)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus_if),
        .out_port(out_port),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Behavioural model state
    bit m_en, m_fade, m_on, m_ramp, m_out;
    int m_period, m_target, m_duty, m_cnt, m_pre;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h) at %0t",
                     tag, got, got, exp, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_fade = 0; m_on = 0; m_ramp = 0; m_out = 0;
        m_period = 1000; m_target = 0; m_duty = 0; m_cnt = 0; m_pre = 0;
    endtask

    function automatic logic [31:0] m_rdata(input logic [1:0] a);
        case (a)
            2'd0:    return {30'd0, m_fade, m_en};
            2'd1:    return 32'(m_period);
            2'd2:    return 32'(m_target);
            default: return {m_duty[15:0], 15'd0, m_ramp};
        endcase
    endfunction

    // One clock of the model, from the inputs currently on the bus.
    task automatic model_step();
        bit n_en, n_fade, active, tick, pb, n_ramp;
        int n_period, tgt, n_duty, n_cnt, n_pre;
        if (!reset_n) begin
            model_reset();
            return;
        end
        n_en = m_en; n_fade = m_fade; n_period = m_period; tgt = m_target;
        if (bus_if.chipselect && !bus_if.write_n) begin
            if (bus_if.address == 2'd0) begin
                n_en   = bus_if.writedata[0];
                n_fade = bus_if.writedata[1];
            end else if (bus_if.address == 2'd1) begin
                n_period = int'(bus_if.writedata & 32'hFFFF);
            end else if (bus_if.address == 2'd2) begin
                tgt = int'(bus_if.writedata & 32'hFFFF);
            end
        end
        active = m_on && m_en;
        tick   = active && (m_pre == CLK_DIV - 1);
        pb     = tick && (m_cnt + 1 >= m_period);
        n_pre  = active ? (m_pre + 1) % CLK_DIV : 0;
        n_cnt  = !active ? 0 : (!tick ? m_cnt : (pb ? 0 : m_cnt + 1));
        n_duty = m_duty;
        n_ramp = m_ramp;
        if (pb) begin
            if (!m_ramp) begin
                if (m_duty != tgt) begin
                    if (m_fade) n_ramp = 1;
                    else        n_duty = tgt;
                end
            end else if (!m_fade) begin
                n_duty = tgt;
                n_ramp = 0;
            end else begin
                if (tgt > m_duty)      n_duty = m_duty + 1;
                else if (tgt < m_duty) n_duty = m_duty - 1;
                if (n_duty == tgt) n_ramp = 0;
            end
        end
        if (!active) n_ramp = 0;
        m_on     = m_en;
        m_out    = n_en && m_on && (n_period != 0) && (n_cnt < n_duty);
        m_en     = n_en;
        m_fade   = n_fade;
        m_period = n_period;
        m_target = tgt;
        m_duty   = n_duty;
        m_cnt    = n_cnt;
        m_pre    = n_pre;
        m_ramp   = n_ramp;
    endtask

    task automatic cyc();
        model_step();
        @(posedge clk);
        @(negedge clk);
        chk("out_port", out_port, m_out);
        chk("busy", busy, m_ramp);
        chk("readdata", bus_if.readdata, m_rdata(bus_if.address));
    endtask

    task automatic bus_wr(input int a, input logic [31:0] d);
        bus_if.address    = 2'(a);
        bus_if.chipselect = 1'b1;
        bus_if.write_n    = 1'b0;
        bus_if.writedata  = d;
        cyc();
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
    endtask

    task automatic bus_rd(input int a, output logic [31:0] d);
        bus_if.address = 2'(a);
        #1;
        d = bus_if.readdata;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic wait_out(input logic v, input string tag);
        for (int i = 0; i < 400 && out_port !== v; i++) cyc();
        chk(tag, out_port, v);
    endtask

    task automatic wait_busy(input logic v, input string tag);
        for (int i = 0; i < 400 && busy !== v; i++) cyc();
        chk(tag, busy, v);
    endtask

    task automatic run_len(input logic v, output int n);
        n = 0;
        while (out_port === v && n < 400) begin
            cyc();
            n++;
        end
    endtask

    task automatic check_reset_reads(input string tag);
        logic [31:0] v;
        logic [31:0] exp [4];
        exp = '{32'd0, 32'd1000, 32'd0, 32'd0};
        for (int a = 0; a < 4; a++) begin
            bus_rd(a, v);
            chk($sformatf("%s_addr%0d", tag, a), v, exp[a]);
        end
    endtask

    // Follow STATUS duty changes; each new value must match the next entry.
    task automatic track_duty(input int seq[$], input string tag);
        logic [31:0] v;
        int prev, idx;
        idx = 0;
        bus_rd(3, v);
        prev = int'(v[31:16]);
        for (int i = 0; i < 800 && idx < seq.size(); i++) begin
            cyc();
            if (int'(bus_if.readdata[31:16]) != prev) begin
                prev = int'(bus_if.readdata[31:16]);
                chk($sformatf("%s_step%0d", tag, idx), 32'(prev), 32'(seq[idx]));
                chk($sformatf("%s_busy%0d", tag, idx), busy, (idx == seq.size() - 1) ? 1'b0 : 1'b1);
                idx++;
            end
        end
        chk({tag, "_done"}, 32'(idx), 32'(seq.size()));
    endtask

    initial begin
        logic [31:0] v;
        int n, h;
        int a;
        logic [31:0] d;

        bus_if.address    = 2'd0;
        bus_if.chipselect = 1'b0;
        bus_if.write_n    = 1'b1;
        bus_if.writedata  = 32'd0;
        reset_n           = 1'b0;
        model_reset();
        idle(3);
        reset_n = 1'b1;
        cyc();
        check_reset_reads("rst");
        chk("rst_out", out_port, 1'b0);
        chk("rst_busy", busy, 1'b0);

        // Basic PWM: 3 of 10 ticks high, 4 clocks per tick
        bus_wr(1, 32'd10);
        bus_wr(2, 32'd3);
        bus_wr(0, 32'd1);
        wait_out(1'b1, "pwm_start");
        run_len(1'b1, n); chk("pwm_hi", 32'(n), 32'd12);
        run_len(1'b0, n); chk("pwm_lo", 32'(n), 32'd28);
        run_len(1'b1, n); chk("pwm_hi2", 32'(n), 32'd12);

        // Duty equal to period: constantly high
        bus_wr(2, 32'd10);
        idle(100);
        h = 0;
        for (int i = 0; i < 40; i++) begin
            cyc();
            if (out_port) h++;
        end
        chk("full_on", 32'(h), 32'd40);

        // Mid-period TARGET change takes effect at the next period
        bus_wr(2, 32'd5);
        idle(100);
        wait_out(1'b0, "mid_lo");
        wait_out(1'b1, "mid_rise");
        h = 0;
        for (int k = 0; k < 60 && out_port; k++) begin
            if (k == 8) bus_wr(2, 32'd2);
            else        cyc();
            h++;
        end
        chk("mid_hi_cur", 32'(h), 32'd20);
        wait_out(1'b1, "mid_rise2");
        run_len(1'b1, n); chk("mid_hi_next", 32'(n), 32'd8);

        // Fade up from 0 to 4
        bus_wr(2, 32'd0);
        idle(100);
        bus_rd(3, v); chk("fade_pre_duty", v[31:16], 32'd0);
        bus_wr(0, 32'd3);
        bus_wr(2, 32'd4);
        wait_busy(1'b1, "fade_busy");
        track_duty('{1, 2, 3, 4}, "ramp_up");

        // Mid-ramp redirect: 2 toward 6, then TARGET=0
        bus_wr(0, 32'd1);
        bus_wr(2, 32'd2);
        idle(100);
        bus_wr(0, 32'd3);
        bus_wr(2, 32'd6);
        wait_busy(1'b1, "redir_busy");
        bus_rd(3, v); chk("redir_duty", v[31:16], 32'd2);
        bus_wr(2, 32'd0);
        track_duty('{1, 0}, "redir");
        bus_wr(0, 32'd0);
        chk("en0_out", out_port, 1'b0);
        bus_rd(3, v); chk("en0_duty", v[31:16], 32'd0);

        // PERIOD=0 keeps the output low
        bus_wr(1, 32'd0);
        bus_wr(2, 32'd5);
        bus_wr(0, 32'd1);
        h = 0;
        for (int i = 0; i < 200; i++) begin
            cyc();
            if (out_port) h++;
        end
        chk("p0_low", 32'(h), 32'd0);

        // Reset in the middle of a ramp
        bus_wr(1, 32'd10);
        bus_wr(0, 32'd3);
        bus_wr(2, 32'd9);
        wait_busy(1'b1, "rr_busy");
        idle(50);
        reset_n = 1'b0;
        cyc();
        reset_n = 1'b1;
        chk("rr_out", out_port, 1'b0);
        chk("rr_busy", busy, 1'b0);
        check_reset_reads("rr");

        // Randomized register traffic against the model
        for (int it = 0; it < 1500; it++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: idle($urandom_range(1, 20));
                3: begin
                    d = $urandom();
                    d[0] = ($urandom_range(0, 9) < 8);
                    bus_wr(0, d);
                end
                4: bus_wr(1, 32'($urandom_range(0, 12)) | ($urandom() & 32'hFFFF0000));
                5, 6: bus_wr(2, 32'($urandom_range(0, 14)) | ($urandom() & 32'hFFFF0000));
                7: bus_wr(3, $urandom());
                8: begin
                    a = $urandom_range(0, 3);
                    bus_rd(a, v);
                    chk("rand_rd", v, m_rdata(2'(a)));
                end
                default: begin
                    if ($urandom_range(0, 9) == 0) begin
                        reset_n = 1'b0;
                        cyc();
                        reset_n = 1'b1;
                    end else begin
                        cyc();
                    end
                end
            endcase
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/lcd_backlight_ctrl.md
LCD_BACKLIGHT_CTRL -- requirements
Module: lcd_backlight_ctrl

Interface
REQ-001 The module SHALL have the parameters listed here, one per line as name, default, meaning.
- CLK_DIV, 4, system clocks per PWM tick; legal range 1..65535.
- RST_PERIOD, 1000, reset value of PERIOD.
- RST_DUTY, 0, reset value of TARGET and of the current duty.
REQ-002 The module SHALL have the ports listed here, one per line as name, direction, width, meaning.
- clk, in, 1, the single clock.
- reset_n, in, 1, reset; synchronous, active-low.
- address, in, 2, register select.
- chipselect, in, 1, slave select.
- write_n, in, 1, active-low write strobe.
- writedata, in, 32, write data.
- readdata, out, 32, read data; combinational from address and registers.
- out_port, out, 1, backlight PWM output.
- busy, out, 1, high while the FSM is in RAMP.
REQ-003 The register map SHALL be as follows.
- 0 CTRL (R/W): bit0 EN, bit1 FADE; other bits read 0.
- 1 PERIOD (R/W): bits[15:0].
- 2 TARGET (R/W): bits[15:0].
- 3 STATUS (RO): readdata = {cur_duty[15:0], 15'b0, busy}; writes ignored.
- Unused bits SHALL read 0.
REQ-004 A write SHALL occur on a rising clk edge with chipselect=1 and write_n=0; the register SHALL update on that edge. There SHALL be no wait states.

Function
REQ-005 A prescaler SHALL count 0..CLK_DIV-1 while EN=1 and emit a 1-clock tick on its terminal count. It SHALL be held at 0 while EN=0.
REQ-006 The PWM counter cnt SHALL be 16 bits wide and advance on each tick, wrapping from PERIOD-1 to 0. The wrap SHALL be called the period boundary (pb).
REQ-007 out_port SHALL be registered: out_port = EN && (PERIOD!=0) && (cnt < cur_duty).
- cur_duty >= PERIOD SHALL give constant high.
- cur_duty = 0 SHALL give constant low.
REQ-008 PERIOD=0 SHALL hold cnt at 0 and out_port low. pb SHALL fire on every tick in this case.
REQ-009 A PERIOD write SHALL take effect immediately. If cnt >= the new PERIOD, cnt SHALL wrap to 0 on the next tick, and that tick SHALL count as pb.
REQ-010 The FSM SHALL have three states: OFF, RUN and RAMP.
REQ-011 OFF behaviour and exit:
- In OFF, cnt, the prescaler and out_port SHALL be 0.
- EN=1 SHALL move the FSM to RUN with cnt=0.
REQ-012 RUN behaviour:
- If cur_duty != TARGET, then on pb:
  - with FADE=0, cur_duty SHALL load TARGET (a glitch-free update: at most one change per period);
  - with FADE=1, the FSM SHALL go to RAMP.
REQ-013 RAMP behaviour:
- On each pb, cur_duty SHALL step by exactly 1 toward TARGET, saturating at TARGET.
- When cur_duty equals TARGET, the FSM SHALL return to RUN on the same edge.
REQ-014 A TARGET write during RAMP SHALL redirect the ramp direction from the next pb, with no restart.
REQ-015 Writing FADE=0 during RAMP SHALL load TARGET into cur_duty at the next pb and return the FSM to RUN.
REQ-016 EN=0 in any state SHALL force the FSM to OFF on the next edge. cur_duty SHALL be retained.
REQ-017 A simultaneous TARGET write and pb SHALL use the new TARGET value on that edge.
REQ-018 busy SHALL be 1 exactly when the state is RAMP.

Reset
REQ-019 With reset_n=0 at a clk edge, the block SHALL set the following values:
- CTRL=0, PERIOD=RST_PERIOD, TARGET=RST_DUTY, cur_duty=RST_DUTY;
- cnt=0, prescaler=0;
- state=OFF, out_port=0, busy=0.
REQ-020 A reset asserted mid-ramp or mid-period SHALL abort the operation. No partial state SHALL survive.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- Reset then read all 4 addresses -> readdata = 0, 1000, 0, 0.
- CLK_DIV=4, PERIOD=10, TARGET=3, CTRL=1 -> out_port high 12 clk, low 28 clk, repeating. TARGET=10 -> constant high.
- PERIOD=10, TARGET=5 running; write TARGET=2 mid-period -> the current period completes with 5 ticks high, the next has 2.
- FADE=1, cur_duty=0, TARGET=4 -> busy=1. cur_duty reads 1, 2, 3, 4 at successive pb. busy falls on the pb where cur_duty=4.
- Mid-ramp (cur_duty=2 toward 6), write TARGET=0 -> cur_duty reads 1 then 0, then busy=0. Next, EN=0 -> out_port=0 within 1 clk and cur_duty reads 0.
- PERIOD=0 with EN=1 -> out_port stays 0. Then reset_n=0 for 1 clk mid-ramp -> all values as REQ-019.
